// File: rtl/rbus_pkg.sv
// Shared types and constants for the register-bus to AXI4-Lite bridge.
// Holds the bridge FSM state encoding, the AXI response codes and the timeout read-back word.
// No logic here; the package only carries typedefs and localparams.
package rbus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } rbus_state_t;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [1:0]  RESP_DECERR  = 2'b11;

  // Returned on dr when a read is abandoned by the response timeout.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/rbus_axil_bridge.sv
// Purpose: turns one-cycle we/re strobes of the simple register bus into single AXI4-Lite write/read transactions.
// Latency: strobe in cycle N, rdy back high in cycle N+3 when the slave answers immediately; longer with slave wait states.
// Backpressure: rdy stays low while a transaction is outstanding; strobes seen outside IDLE are dropped. Optional RBUS_TIMEOUT_EN adds a response timeout.
module rbus_axil_bridge
  import rbus_pkg::*;
#(
  parameter int AXI_AW  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              xreset,
  input  logic [31:0]       adr,
  input  logic              we,
  input  logic              re,
  output logic              rdy,
  input  logic [31:0]       dw,
  output logic [31:0]       dr,
  output logic              err,
  output logic [AXI_AW-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [AXI_AW-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  rbus_state_t       state, state_nxt;
  logic [AXI_AW-1:0] awaddr_nxt, araddr_nxt;
  logic [31:0]       wdata_nxt, dr_nxt;
  logic [3:0]        wstrb_nxt;
  logic              awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt, err_nxt;

`ifdef RBUS_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT) + 1;
  logic [TCNT_W-1:0] tcnt;

  // Cycles spent outside IDLE; restarts from zero every time the FSM leaves IDLE.
  always_ff @(posedge clk) begin
    if (!xreset || state == IDLE) tcnt <= '0;
    else                          tcnt <= tcnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign rdy = (state == IDLE);

  // Next state and next values of every registered output; all AXI-facing outputs come straight from flops.
  always_comb begin
    state_nxt   = state;
    awaddr_nxt  = m_awaddr;
    araddr_nxt  = m_araddr;
    wdata_nxt   = m_wdata;
    wstrb_nxt   = m_wstrb;
    dr_nxt      = dr;
    err_nxt     = err;
    awvalid_nxt = m_awvalid;
    wvalid_nxt  = m_wvalid;
    bready_nxt  = m_bready;
    arvalid_nxt = m_arvalid;
    rready_nxt  = m_rready;
    case (state)
      IDLE: begin
        if (we) begin
          awaddr_nxt  = adr[AXI_AW-1:0];
          wdata_nxt   = dw;
          wstrb_nxt   = 4'hF;
          awvalid_nxt = 1'b1;
          wvalid_nxt  = 1'b1;
          state_nxt   = WADDR;
        end else if (re) begin
          araddr_nxt  = adr[AXI_AW-1:0];
          arvalid_nxt = 1'b1;
          state_nxt   = RADDR;
        end
      end
      WADDR: begin
        // AW and W complete independently; a channel already done just stays low.
        if (m_awready) awvalid_nxt = 1'b0;
        if (m_wready)  wvalid_nxt  = 1'b0;
        if (!awvalid_nxt && !wvalid_nxt) begin
          bready_nxt = 1'b1;
          state_nxt  = WRESP;
        end
      end
      WRESP: begin
        if (m_bvalid) begin
          bready_nxt = 1'b0;
          err_nxt    = err | (m_bresp != RESP_OKAY);
          state_nxt  = IDLE;
        end
      end
      RADDR: begin
        if (m_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RDATA;
        end
      end
      RDATA: begin
        if (m_rvalid) begin
          dr_nxt     = m_rdata;
          err_nxt    = err | (m_rresp != RESP_OKAY);
          rready_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef RBUS_TIMEOUT_EN
    // Give up on a silent slave: drop every handshake signal so a late response is never accepted.
    if (state != IDLE && tcnt == TCNT_W'(TIMEOUT - 1)) begin
      awvalid_nxt = 1'b0;
      wvalid_nxt  = 1'b0;
      bready_nxt  = 1'b0;
      arvalid_nxt = 1'b0;
      rready_nxt  = 1'b0;
      err_nxt     = 1'b1;
      if (state == RADDR || state == RDATA) dr_nxt = TIMEOUT_DATA;
      state_nxt   = IDLE;
    end
`endif
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!xreset) begin
      state     <= IDLE;
      m_awaddr  <= '0;
      m_araddr  <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      dr        <= '0;
      err       <= 1'b0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      m_awaddr  <= awaddr_nxt;
      m_araddr  <= araddr_nxt;
      m_wdata   <= wdata_nxt;
      m_wstrb   <= wstrb_nxt;
      dr        <= dr_nxt;
      err       <= err_nxt;
      m_awvalid <= awvalid_nxt;
      m_wvalid  <= wvalid_nxt;
      m_bready  <= bready_nxt;
      m_arvalid <= arvalid_nxt;
      m_rready  <= rready_nxt;
    end
  end

endmodule

// File: tb/tb_rbus_axil_bridge.sv
// Directed bench for rbus_axil_bridge with a configurable-latency AXI4-Lite slave.
// Inputs and slave responses change on the falling edge; outputs are checked on the falling edge.
// Build with RBUS_TIMEOUT_EN defined to include the timeout scenario (TIMEOUT=16).
module tb_rbus_axil_bridge;

  logic        clk = 1'b0;
  logic        xreset = 1'b0;
  logic [31:0] adr = '0, dw = '0, dr;
  logic        we = 1'b0, re = 1'b0, rdy, err;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0, m_arready = 1'b0, m_rvalid = 1'b0;
  logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
  logic [31:0] m_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // slave configuration, written by the test sequence between transactions
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  bit          ar_never = 1'b0;
  logic [31:0] rdata_cfg = '0;
  logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;

  // slave-internal wait counters and monitor counters
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int aw_hi = 0, w_hi = 0, ar_hi = 0;

  rbus_axil_bridge #(.AXI_AW(32), .TIMEOUT(16)) dut (
    .clk(clk), .xreset(xreset), .adr(adr), .we(we), .re(re), .rdy(rdy), .dw(dw), .dr(dr), .err(err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // slave: each ready/valid response appears a configurable number of cycles after the request
  always @(negedge clk) begin
    if (m_awvalid === 1'b1) begin m_awready = (aw_cnt >= aw_delay); aw_cnt++; end
    else begin m_awready = 1'b0; aw_cnt = 0; end
    if (m_wvalid === 1'b1) begin m_wready = (w_cnt >= w_delay); w_cnt++; end
    else begin m_wready = 1'b0; w_cnt = 0; end
    if (m_bready === 1'b1) begin m_bvalid = (b_cnt >= b_delay); b_cnt++; m_bresp = bresp_cfg; end
    else begin m_bvalid = 1'b0; b_cnt = 0; m_bresp = 2'b11; end
    if (m_arvalid === 1'b1) begin m_arready = !ar_never && (ar_cnt >= ar_delay); ar_cnt++; end
    else begin m_arready = 1'b0; ar_cnt = 0; end
    if (m_rready === 1'b1) begin
      m_rvalid = (r_cnt >= r_delay); r_cnt++;
      m_rdata  = m_rvalid ? rdata_cfg : 32'h0BAD0BAD;
      m_rresp  = m_rvalid ? rresp_cfg : 2'b11;
    end else begin
      m_rvalid = 1'b0; r_cnt = 0; m_rdata = 32'h0BAD0BAD; m_rresp = 2'b11;
    end
  end

  // handshake and valid-high monitors
  always @(posedge clk) begin
    if (m_awvalid) aw_hi++;
    if (m_wvalid)  w_hi++;
    if (m_arvalid) ar_hi++;
    if (m_awvalid && m_awready) aw_hs++;
    if (m_wvalid && m_wready)   w_hs++;
    if (m_bvalid && m_bready)   b_hs++;
    if (m_arvalid && m_arready) ar_hs++;
    if (m_rvalid && m_rready)   r_hs++;
  end

  // Drive one strobe in the current cycle; returns at the falling edge of the next cycle.
  task automatic strobe(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    we = w; re = r; adr = a; dw = d;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  // Counts cycles since the strobe (already 1 on entry) until rdy is seen high.
  task automatic wait_idle(input string nm, input int budget, output int cyc);
    cyc = 1;
    while (rdy !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_rdy_timeout: rdy=%b after %0d cycles, required 1", nm, rdy, cyc);
    end
  endtask

  task automatic test_reset();
    xreset = 1'b0; we = 1'b0; re = 1'b0; adr = '0; dw = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %b want 1", rdy); end
    n_cmp++; if (dr !== 32'h0) begin n_bad++; $display("FAIL reset_dr: got %h want 0", dr); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_vld_rdy: got %b want 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    n_cmp++;
    if ({m_awaddr, m_wdata, m_araddr, m_wstrb} !== 100'h0) begin
      n_bad++;
      $display("FAIL reset_regs: awaddr=%h wdata=%h araddr=%h wstrb=%h want all 0", m_awaddr, m_wdata, m_araddr, m_wstrb);
    end
    xreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_basic();
    int a0, w0, b0, cyc;
    a0 = aw_hs; w0 = w_hs; b0 = b_hs;
    strobe(1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678);
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_rdy: got %b want 0", rdy); end
    n_cmp++; if (m_awaddr !== 32'h10) begin n_bad++; $display("FAIL wr_awaddr: got %h want 00000010", m_awaddr); end
    n_cmp++; if (m_wdata !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_wdata: got %h want 12345678", m_wdata); end
    n_cmp++; if (m_wstrb !== 4'hF) begin n_bad++; $display("FAIL wr_wstrb: got %h want f", m_wstrb); end
    n_cmp++; if ({m_awvalid, m_wvalid} !== 2'b11) begin n_bad++; $display("FAIL wr_valids: got %b want 11", {m_awvalid, m_wvalid}); end
    wait_idle("wr_basic", 50, cyc);
    n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", cyc); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b want 0", err); end
    n_cmp++;
    if (aw_hs - a0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
      n_bad++;
      $display("FAIL wr_handshakes: aw=%0d w=%0d b=%0d want 1 1 1", aw_hs - a0, w_hs - w0, b_hs - b0);
    end
  endtask

  task automatic test_read_wait();
    int cyc;
    r_delay = 5; rdata_cfg = 32'hCAFE_F00D; rresp_cfg = 2'b00;
    strobe(1'b0, 1'b1, 32'h0000_0014, 32'h0);
    n_cmp++; if (m_araddr !== 32'h14) begin n_bad++; $display("FAIL rd_araddr: got %h want 00000014", m_araddr); end
    n_cmp++; if ({m_arvalid, rdy} !== 2'b10) begin n_bad++; $display("FAIL rd_arvalid_rdy: got %b want 10", {m_arvalid, rdy}); end
    wait_idle("rd_wait", 50, cyc);
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL rd_latency: got %0d want 8", cyc); end
    n_cmp++; if (dr !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL rd_dr: got %h want cafef00d", dr); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({rdy, dr} !== {1'b1, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL rd_dr_hold: rdy=%b dr=%h want 1 cafef00d", rdy, dr); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b want 0", err); end
    r_delay = 0;
  endtask

  task automatic test_write_wdelay();
    int ah0, wh0, b0, cyc;
    w_delay = 4;
    ah0 = aw_hi; wh0 = w_hi; b0 = b_hs;
    strobe(1'b1, 1'b0, 32'h0000_0018, 32'h0F0F_0F0F);
    wait_idle("wr_wdelay", 50, cyc);
    n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL wdly_latency: got %0d want 7", cyc); end
    n_cmp++; if (aw_hi - ah0 != 1) begin n_bad++; $display("FAIL wdly_awvalid_cycles: got %0d want 1", aw_hi - ah0); end
    n_cmp++; if (w_hi - wh0 != 5) begin n_bad++; $display("FAIL wdly_wvalid_cycles: got %0d want 5", w_hi - wh0); end
    n_cmp++; if (b_hs - b0 != 1) begin n_bad++; $display("FAIL wdly_b_handshakes: got %0d want 1", b_hs - b0); end
    w_delay = 0;
  endtask

  task automatic test_we_re_same();
    int a0, w0, b0, arh0, cyc;
    a0 = aw_hs; w0 = w_hs; b0 = b_hs; arh0 = ar_hi;
    strobe(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
    re = 1'b1; adr = 32'h0000_0024;
    @(negedge clk);
    re = 1'b0;
    wait_idle("we_re", 50, cyc);
    n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL wr_re_latency: got %0d want 2 more cycles", cyc); end
    repeat (3) @(negedge clk);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL wr_re_idle_rdy: got %b want 1", rdy); end
    n_cmp++; if (ar_hi - arh0 != 0) begin n_bad++; $display("FAIL wr_re_no_ar: arvalid cycles %0d want 0", ar_hi - arh0); end
    n_cmp++;
    if (aw_hs - a0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
      n_bad++;
      $display("FAIL wr_re_one_write: aw=%0d w=%0d b=%0d want 1 1 1", aw_hs - a0, w_hs - w0, b_hs - b0);
    end
    n_cmp++;
    if ({m_awaddr, m_wdata} !== {32'h20, 32'hA5A5_A5A5}) begin
      n_bad++;
      $display("FAIL wr_re_addr_data: awaddr=%h wdata=%h want 00000020 a5a5a5a5", m_awaddr, m_wdata);
    end
  endtask

  task automatic test_err_read();
    int cyc;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_pre: got %b want 0", err); end
    rresp_cfg = 2'b10; rdata_cfg = 32'h1;
    strobe(1'b0, 1'b1, 32'h0000_001C, 32'h0);
    wait_idle("err_rd", 50, cyc);
    n_cmp++; if (dr !== 32'h1) begin n_bad++; $display("FAIL err_rd_dr: got %h want 00000001", dr); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_rd_err: got %b want 1", err); end
    rresp_cfg = 2'b00; bresp_cfg = 2'b00;
    strobe(1'b1, 1'b0, 32'h0000_0010, 32'h5555_AAAA);
    wait_idle("err_wr", 50, cyc);
    n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL err_wr_latency: got %0d want 3", cyc); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

`ifdef RBUS_TIMEOUT_EN
  task automatic test_timeout();
    int arh0, cyc;
    xreset = 1'b0; @(negedge clk); xreset = 1'b1; @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_pre_err: got %b want 0", err); end
    ar_never = 1'b1;
    arh0 = ar_hi;
    strobe(1'b0, 1'b1, 32'h0000_0030, 32'h0);
    wait_idle("timeout", 100, cyc);
    n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL to_latency: got %0d want 17", cyc); end
    n_cmp++; if (ar_hi - arh0 != 16) begin n_bad++; $display("FAIL to_arvalid_cycles: got %0d want 16", ar_hi - arh0); end
    n_cmp++; if (m_arvalid !== 1'b0) begin n_bad++; $display("FAIL to_arvalid: got %b want 0", m_arvalid); end
    n_cmp++; if (dr !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL to_dr: got %h want deadbeef", dr); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", err); end
    ar_never = 1'b0;
    xreset = 1'b0; @(negedge clk); xreset = 1'b1; @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_reset_err: got %b want 0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_write_wdelay();
    test_we_re_same();
    test_err_read();
`ifdef RBUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
